// File: rtl/fir_feeder.sv
// ---------------------------------------------------------------------------
// fir_feeder : frames a byte stream into FIR coefficient loads and samples
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_feeder #(
  parameter logic [7:0] HDR_COEF = 8'hC5,
  parameter logic [7:0] HDR_SAMP = 8'hA5
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] Data_o,
  output logic       Data_valid,
  output logic [7:0] B0,
  output logic [7:0] B1,
  output logic [7:0] B2,
  output logic [7:0] B3,
  output logic [7:0] B4,
  output logic [7:0] B5,
  output logic [7:0] B6,
  output logic       coef_valid,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COEF   = 3'd1,
    ST_CHK    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_LEN    = 3'd4,
    ST_SAMP   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      n_q, n_d;
  logic [6:0][7:0] s_q, s_d;
  logic [6:0][7:0] b_q, b_d;
  logic            cv_q, cv_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            err_q, err_d;
  logic            xfer;
  logic [7:0]      checksum;

  // Ready is gated by reset so the upstream never sees a transfer mid-reset.
  assign in_ready = Rst_n && (state_q != ST_COMMIT);
  assign xfer     = in_valid && in_ready;
  assign checksum = s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[3] ^ s_q[4] ^ s_q[5] ^ s_q[6];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    s_d     = s_q;
    b_d     = b_q;
    cv_d    = cv_q;
    data_d  = 8'h00;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (xfer) begin
        if (in_data == HDR_COEF) begin
          state_d = ST_COEF;
          idx_d   = 3'd0;
        end else if (in_data == HDR_SAMP) begin
          state_d = ST_LEN;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_COEF: if (xfer) begin
        s_d[idx_q] = in_data;
        if (idx_q == 3'd6) begin
          state_d = ST_CHK;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_CHK: if (xfer) begin
        if (in_data == checksum) begin
          state_d = ST_COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        b_d     = s_q;
        cv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_LEN: if (xfer) begin
        n_d = in_data;
        if (in_data == 8'h00) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SAMP;
        end
      end
      ST_SAMP: if (xfer) begin
        n_d    = n_q - 8'd1;
        data_d = in_data;
        dv_d   = 1'b1;
        if (n_q == 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      n_q     <= 8'h00;
      s_q     <= '0;
      b_q     <= '0;
      cv_q    <= 1'b0;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cv_q    <= cv_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign Data_o     = data_q;
  assign Data_valid = dv_q;
  assign coef_valid = cv_q;
  assign frame_err  = err_q;
  assign B0 = b_q[0];
  assign B1 = b_q[1];
  assign B2 = b_q[2];
  assign B3 = b_q[3];
  assign B4 = b_q[4];
  assign B5 = b_q[5];
  assign B6 = b_q[6];

endmodule

`default_nettype wire

// File: tb/tb_fir_feeder.sv
// ---------------------------------------------------------------------------
// tb_fir_feeder : directed-vector bench for fir_feeder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_feeder;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Data_o;
  logic       Data_valid;
  logic [7:0] B0, B1, B2, B3, B4, B5, B6;
  logic       coef_valid;
  logic       frame_err;

  int n_vec = 0;
  int n_err = 0;

  wire [55:0] b_bus = {B0, B1, B2, B3, B4, B5, B6};

  fir_feeder #(.HDR_COEF(8'hC5), .HDR_SAMP(8'hA5)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Data_o     (Data_o),
    .Data_valid (Data_valid),
    .B0         (B0),
    .B1         (B1),
    .B2         (B2),
    .B3         (B3),
    .B4         (B4),
    .B5         (B5),
    .B6         (B6),
    .coef_valid (coef_valid),
    .frame_err  (frame_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_coefs(input string tag, input logic [55:0] exp);
    for (int i = 0; i < 7; i++)
      check_eq($sformatf("%s_B%0d", tag, i), {24'h0, b_bus[55-8*i -: 8]}, {24'h0, exp[55-8*i -: 8]});
  endtask

  // Present one byte, hold it until it transfers (bounded), return #1 after that edge.
  task automatic send(input logic [7:0] b);
    logic rdy;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      rdy = in_ready;
      @(posedge Clk);
      if (rdy) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    check_eq($sformatf("xfer_%02h", b), {31'h0, done}, 32'h1);
  endtask

  task automatic idle_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v);
    @(negedge Clk);
    check_eq({tag, "_data"}, {24'h0, Data_o}, {24'h0, d});
    check_eq({tag, "_dv"}, {31'h0, Data_valid}, {31'h0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge Clk);

    // Reset state
    @(negedge Clk);
    check_eq("rst_ready", {31'h0, in_ready}, 32'h0);
    check_eq("rst_data", {24'h0, Data_o}, 32'h0);
    check_eq("rst_dv", {31'h0, Data_valid}, 32'h0);
    check_eq("rst_cv", {31'h0, coef_valid}, 32'h0);
    check_eq("rst_err", {31'h0, frame_err}, 32'h0);
    check_coefs("rst", 56'h0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("post_rst_ready", {31'h0, in_ready}, 32'h1);

    // Coefficient load with checksum 00
    send(8'hC5);
    for (int i = 1; i <= 7; i++) send(8'(i));
    send(8'h00);
    @(negedge Clk);
    check_eq("commit_ready", {31'h0, in_ready}, 32'h0);
    check_eq("commit_cv_pre", {31'h0, coef_valid}, 32'h0);
    idle_cycle();
    @(negedge Clk);
    check_eq("commit_ready_after", {31'h0, in_ready}, 32'h1);
    check_eq("commit_cv", {31'h0, coef_valid}, 32'h1);
    check_coefs("load1", 56'h01020304050607);

    // Bad checksum leaves coefficients untouched
    send(8'hC5);
    for (int i = 0; i < 7; i++) send(8'h09);
    send(8'hFF);
    @(negedge Clk);
    check_eq("badck_err", {31'h0, frame_err}, 32'h1);
    check_eq("badck_ready", {31'h0, in_ready}, 32'h1);
    idle_cycle();
    @(negedge Clk);
    check_eq("badck_err_clr", {31'h0, frame_err}, 32'h0);
    check_eq("badck_cv", {31'h0, coef_valid}, 32'h1);
    check_coefs("badck", 56'h01020304050607);

    // Back-to-back sample frame
    send(8'hA5);
    send(8'h03);
    check_out("len", 8'h00, 1'b0);
    send(8'h10);
    check_out("s10", 8'h10, 1'b1);
    send(8'h20);
    check_out("s20", 8'h20, 1'b1);
    send(8'h30);
    check_out("s30", 8'h30, 1'b1);
    idle_cycle();
    check_out("s_end", 8'h00, 1'b0);

    // Frame with a 4-cycle gap
    send(8'hA5);
    send(8'h02);
    send(8'hAA);
    check_out("gAA", 8'hAA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      check_out($sformatf("gap%0d", i), 8'h00, 1'b0);
    end
    send(8'hBB);
    check_out("gBB", 8'hBB, 1'b1);
    idle_cycle();
    check_out("g_end", 8'h00, 1'b0);

    // Stray byte in IDLE (also proves the 2-sample frame ended)
    send(8'h3C);
    @(negedge Clk);
    check_eq("stray_err", {31'h0, frame_err}, 32'h1);
    idle_cycle();
    @(negedge Clk);
    check_eq("stray_err_clr", {31'h0, frame_err}, 32'h0);

    // Zero length, then a clean load with checksum 01
    send(8'hA5);
    send(8'h00);
    @(negedge Clk);
    check_eq("zlen_err", {31'h0, frame_err}, 32'h1);
    send(8'hC5);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'h50); send(8'h60); send(8'h71);
    send(8'h01);
    idle_cycle();
    @(negedge Clk);
    check_eq("load2_err", {31'h0, frame_err}, 32'h0);
    check_coefs("load2", 56'h10203040506071);

    // Reset mid-load, then a single-sample frame
    send(8'hC5);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    Rst_n = 1'b0;
    @(negedge Clk);
    check_eq("midrst_ready", {31'h0, in_ready}, 32'h0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("midrst_cv", {31'h0, coef_valid}, 32'h0);
    check_eq("midrst_ready_after", {31'h0, in_ready}, 32'h1);
    check_coefs("midrst", 56'h0);
    send(8'hA5);
    send(8'h01);
    send(8'h44);
    check_out("s44", 8'h44, 1'b1);
    idle_cycle();
    check_out("s44_end", 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
